// File: rtl/ws28xx_ctl.sv
// ws28xx_ctl: buffers one pixel ahead and streams it MSB-first to the WS28xx bit generator.
// Build option: define WS28XX_CTL_RGBW_EN for 32-bit RGBW pixels (default 24-bit RGB).
module ws28xx_ctl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] data_i,
  input  logic        data_last_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic        bit_data_o,
  output logic        bit_valid_o,
  input  logic        bit_ready_i,
  input  logic [15:0] reg_rst_time_i,
  output logic        busy_o,
  output logic        underrun_o,
  output logic        frame_done_o
);

`ifdef WS28XX_CTL_RGBW_EN
  localparam int N = 32;
`else
  localparam int N = 24;
  logic unused_hi_bits;
  assign unused_hi_bits = ^data_i[31:24];
`endif

  typedef enum logic [1:0] {IDLE, SEND, STALL, LATCH} state_t;

  state_t       state;
  logic [N-1:0] hold_data;
  logic         hold_last;
  logic         hold_vld;
  logic [N-1:0] shift;
  logic         shift_last;
  logic [4:0]   bit_cnt;
  logic [15:0]  lat_cnt;
  logic         bit_valid_q;
  logic         underrun_q;
  logic         accept;
  logic         last_bit_done;
  logic         load;

  // Handshakes (all valid/ready): a transfer happens on the rising clock edge where both
  // valid and ready are high. Upstream pixels: data_valid_i/data_ready_o. Generator side:
  // bit_valid_o/bit_ready_i, where bit_ready_i is a one-cycle "bit finished" pulse.
  assign data_ready_o  = ~hold_vld & (state != LATCH);
  assign accept        = data_valid_i & data_ready_o;
  assign last_bit_done = (state == SEND) & bit_ready_i & (bit_cnt == 5'd0);

  // The hold register drains into the shifter whenever the shifter is free to take a pixel.
  always_comb begin
    load = 1'b0;
    if (hold_vld) begin
      case (state)
        IDLE, STALL: load = 1'b1;
        SEND:        load = last_bit_done & ~shift_last;
        default:     load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_vld  <= 1'b0;
    end else if (accept) begin
      hold_data <= data_i[N-1:0];
      hold_last <= data_last_i;
      hold_vld  <= 1'b1;
    end else if (load) begin
      hold_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      shift       <= '0;
      shift_last  <= 1'b0;
      bit_cnt     <= 5'd0;
      lat_cnt     <= 16'd0;
      bit_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (load) begin
        shift      <= hold_data;
        shift_last <= hold_last;
        bit_cnt    <= 5'(N - 1);
      end
      case (state)
        IDLE, STALL: begin
          if (hold_vld) begin
            state       <= SEND;
            bit_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (bit_ready_i) begin
            if (bit_cnt != 5'd0) begin
              shift   <= {shift[N-2:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
            end else if (shift_last) begin
              state       <= LATCH;
              lat_cnt     <= 16'd0;
              bit_valid_q <= 1'b0;
            end else if (!hold_vld) begin
              state       <= STALL;
              bit_valid_q <= 1'b0;
              underrun_q  <= 1'b1;
            end
          end
        end
        LATCH: begin
          // Live compare: lowering reg_rst_time_i below the count runs on to the 16-bit wrap.
          if (lat_cnt == reg_rst_time_i) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 16'd1;
          end
        end
        default: begin
          state       <= IDLE;
          bit_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bit_data_o   = shift[N-1];
  assign bit_valid_o  = bit_valid_q;
  assign underrun_o   = underrun_q;
  assign frame_done_o = (state == LATCH) & (lat_cnt == reg_rst_time_i);
  assign busy_o       = (state != IDLE) | hold_vld;

endmodule

// File: tb/tb_ws28xx_ctl.sv
// tb_ws28xx_ctl: randomized bench for ws28xx_ctl with a bit-level expected queue.
// Follows WS28XX_CTL_RGBW_EN exactly like the design (24 or 32 bits per pixel).
module tb_ws28xx_ctl;

`ifdef WS28XX_CTL_RGBW_EN
  localparam int N = 32;
`else
  localparam int N = 24;
`endif
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic        data_last = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        bit_data;
  logic        bit_valid;
  logic        bit_ready = 1'b0;
  logic [15:0] reg_rst_time = 16'h0;
  logic        busy;
  logic        underrun;
  logic        frame_done;

  ws28xx_ctl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .data_i         (data),
    .data_last_i    (data_last),
    .data_valid_i   (data_valid),
    .data_ready_o   (data_ready),
    .bit_data_o     (bit_data),
    .bit_valid_o    (bit_valid),
    .bit_ready_i    (bit_ready),
    .reg_rst_time_i (reg_rst_time),
    .busy_o         (busy),
    .underrun_o     (underrun),
    .frame_done_o   (frame_done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  // exp_q entries: bit 0 = expected line bit, bit 1 = last bit of a frame
  logic [W-1:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  bit prev_valid = 1'b0;
  bit in_frame = 1'b0;
  bit latch_active = 1'b0;
  int t_last = 0;
  int acc_f = -1;
  int acc_i = -1;
  int under_cnt = 0;
  int gap_cnt = 0;
  int done_cnt = 0;
  int frames_sent = 0;
  int under_err = 0;
  int ready_err = 0;
  int latch_err = 0;
  int busy_err = 0;
  logic [31:0] cap = 32'h0;
  logic [31:0] last_cap = 32'h0;
  logic [31:0] nmask;
  int gen_delay = 0;
  int gcnt = 0;
  bit gen_rand = 1'b0;
  bit stray_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // ---------------- generator model ----------------
  initial begin : generator
    forever begin
      @(negedge clk);
      bit_ready = 1'b0;
      if (bit_valid) begin
        if (gcnt >= gen_delay) begin
          bit_ready = 1'b1;
          gcnt = 0;
          if (gen_rand) gen_delay = $urandom_range(0, 3);
        end else begin
          gcnt++;
        end
      end else begin
        gcnt = 0;
        if (stray_en && $urandom_range(0, 3) == 0) bit_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        cyc++;
        if (latch_active) begin
          if (data_ready) ready_err++;
          if (bit_valid) latch_err++;
        end
        if ((in_frame || latch_active) && !busy) busy_err++;
        if (underrun !== (in_frame && !bit_valid && prev_valid)) under_err++;
        if (underrun) under_cnt++;
        if (in_frame && !bit_valid) gap_cnt++;
        if (data_valid && data_ready) begin
          if (in_frame && !bit_valid) acc_f = cyc;
          else if (!in_frame && !latch_active && !bit_valid) acc_i = cyc;
        end
        if (bit_valid && !prev_valid) begin
          if (in_frame && acc_f >= 0) check("resume_latency", cyc - acc_f, 2);
          if (!in_frame && acc_i >= 0) check("start_latency", cyc - acc_i, 2);
          acc_f = -1;
          acc_i = -1;
        end
        if (bit_valid && !in_frame) begin
          in_frame = 1'b1;
          cap = 32'h0;
        end
        if (bit_valid && bit_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bit_q", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("bit_data", bit_data, e[0]);
            cap = {cap[30:0], bit_data};
            if (e[1]) begin
              in_frame = 1'b0;
              latch_active = 1'b1;
              t_last = cyc;
            end
          end
        end
        if (frame_done) begin
          if (!latch_active) begin
            check("spurious_done", frame_done, 0);
          end else begin
            check("latch_len", cyc - t_last, reg_rst_time + 1);
            latch_active = 1'b0;
            done_cnt++;
            last_cap = cap;
          end
        end
        prev_valid = bit_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pixel(input logic [31:0] d, input logic last);
    for (int i = N - 1; i >= 0; i--) exp_q.push_back({(last && i == 0), d[i]});
  endtask

  // Leaves data_valid high on return so callers can stream back-to-back.
  task automatic send_pixel(input logic [31:0] d, input logic last);
    int n = 0;
    data = d;
    data_last = last;
    data_valid = 1'b1;
    while (!data_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) begin
      check("accept_timeout", data_ready, 1);
      data_valid = 1'b0;
    end else begin
      push_pixel(d, last);
      if (last) frames_sent++;
      @(negedge clk);
    end
  endtask

  task automatic release_data();
    data_valid = 1'b0;
    data = $urandom;
    data_last = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    release_data();
    while ((exp_q.size() != 0 || latch_active || in_frame || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", busy, 0);
    check("frames_done", done_cnt, frames_sent);
    check("bits_left", exp_q.size(), 0);
  endtask

  task automatic wait_queue_le(input int lim);
    int n = 0;
    while (exp_q.size() > lim && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > lim) check("queue_drain_timeout", exp_q.size(), lim);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit_valid"}, bit_valid, 0);
    check({tag, "_bit_data"}, bit_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_data_ready"}, data_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int u0;
    int g0;
    int l0;
    int npix;
    nmask = (N == 32) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;

    // reset state
    rst_n = 1'b0;
    wait_cycles(3);
    #1;
    check_reset_outputs("rst");
    #1 rst_n = 1'b1;
    #1 check("ready_after_release", data_ready, 1);
    @(negedge clk);

    // single known pixel, fixed generator delay
    reg_rst_time = 16'd10;
    gen_delay = 5;
    send_pixel(32'h0000_A5F0, 1'b1);
    wait_idle();
    check("pix_a5f0_bits", last_cap & nmask, 32'h0000_A5F0 & nmask);

    // three pixels streamed back-to-back
    gen_rand = 1'b1;
    stray_en = 1'b1;
    reg_rst_time = 16'($urandom_range(0, 20));
    u0 = under_cnt;
    g0 = gap_cnt;
    send_pixel($urandom, 1'b0);
    send_pixel($urandom, 1'b0);
    send_pixel($urandom, 1'b1);
    wait_idle();
    check("stream_underrun", under_cnt - u0, 0);
    check("stream_gap", gap_cnt - g0, 0);

    // second pixel withheld: one stall
    gen_rand = 1'b0;
    stray_en = 1'b0;
    gen_delay = 1;
    reg_rst_time = 16'd5;
    u0 = under_cnt;
    g0 = gap_cnt;
    send_pixel($urandom, 1'b0);
    release_data();
    wait_queue_le(0);
    wait_cycles(20);
    send_pixel($urandom, 1'b1);
    wait_idle();
    check("stall_underrun", under_cnt - u0, 1);
    check("stall_gap", gap_cnt - g0, 22);

    // pixel offered while latching
    gen_delay = 0;
    reg_rst_time = 16'd30;
    send_pixel($urandom, 1'b1);
    release_data();
    while (!latch_active && exp_q.size() != 0) @(negedge clk);
    wait_cycles(3);
    l0 = done_cnt;
    send_pixel($urandom, 1'b0);
    check("accept_after_latch", done_cnt - l0, 1);
    send_pixel($urandom, 1'b1);
    wait_idle();

    // asynchronous reset in the middle of pixel 2
    gen_delay = 2;
    send_pixel($urandom, 1'b0);
    send_pixel($urandom, 1'b0);
    release_data();
    wait_queue_le(N - 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    in_frame = 1'b0;
    latch_active = 1'b0;
    acc_f = -1;
    acc_i = -1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("midrst_ready_release", data_ready, 1);
    @(negedge clk);
    reg_rst_time = 16'd4;
    send_pixel($urandom, 1'b0);
    send_pixel($urandom, 1'b1);
    wait_idle();

    // randomized frames, first with zero latch time
    gen_rand = 1'b1;
    stray_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      reg_rst_time = (f == 0) ? 16'd0 : 16'($urandom_range(0, 40));
      npix = $urandom_range(1, 4);
      for (int p = 0; p < npix; p++) begin
        send_pixel($urandom, (p == npix - 1));
        if ($urandom_range(0, 2) == 0) begin
          release_data();
          wait_cycles($urandom_range(1, 60));
        end
      end
      wait_idle();
    end

    // first and last bit set, all others clear
    gen_rand = 1'b0;
    stray_en = 1'b0;
    gen_delay = 1;
    reg_rst_time = 16'd3;
    send_pixel(32'h8000_0001 | (32'h0080_0000 & ~nmask & 32'h0) | ((N == 24) ? 32'h0080_0000 : 32'h0), 1'b1);
    wait_idle();
    check("first_last_bits", last_cap & nmask, (N == 24) ? 32'h0080_0001 : 32'h8000_0001);

    check("underrun_rule_errs", under_err, 0);
    check("latch_ready_errs", ready_err, 0);
    check("latch_valid_errs", latch_err, 0);
    check("busy_errs", busy_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ws28xx_ctl.md
# ws28xx_ctl

Pixel-to-bit sequencer that feeds the WS28xx bit-code generator. Accepts 24-bit (or 32-bit RGBW) pixel words from an upstream stream, buffers one pixel ahead, and presents bits MSB-first on the generator's `bit_data`/`bit_valid`/`bit_ready` handshake so consecutive pixels go out back-to-back. After the pixel flagged `last`, it holds the line idle for a programmable latch/reset period, then pulses `frame_done_o`.

## Interface
- No parameters; all timing via register inputs.
- `clk_i`  in  1  system clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `data_i`  in  32  pixel word; bit 23 (bit 31 with RGBW) sent first
- `data_last_i`  in  1  pixel is last of frame
- `data_valid_i`  in  1  pixel word valid
- `data_ready_o`  out  1  pixel accepted when `data_valid_i & data_ready_o`
- `bit_data_o`  out  1  current bit to generator; stable while `bit_valid_o` high until `bit_ready_i`
- `bit_valid_o`  out  1  bit available to generator
- `bit_ready_i`  in  1  one-cycle pulse from generator: current bit finished
- `reg_rst_time_i`  in  16  latch period; line idle for `reg_rst_time_i + 1` cycles
- `busy_o`  out  1  state ≠ IDLE or hold register full
- `underrun_o`  out  1  one-cycle pulse on entering STALL
- `frame_done_o`  out  1  one-cycle pulse on LATCH exit

## Operation
- Storage: hold register (`hold_data`, `hold_last`, `hold_vld`), shift register (`shift`, `shift_last`), bit counter `bit_cnt` 5 bits, latch counter 16 bits.
- `data_ready_o = ~hold_vld & (state != LATCH)`; handshake writes hold register, sets `hold_vld`.
- N = 24 bits/pixel (32 with RGBW). `bit_data_o = shift[N-1]`.
- States:
  - IDLE: `bit_valid_o=0`. If `hold_vld`: load shift from hold, `bit_cnt=N-1`, clear `hold_vld`, → SEND.
  - SEND: `bit_valid_o=1`. On `bit_ready_i`: if `bit_cnt≠0`, shift left 1, decrement. If `bit_cnt==0`: if `shift_last` → LATCH (counter=0); else if `hold_vld` → load from hold, stay SEND (no gap); else → STALL, pulse `underrun_o`.
  - STALL: `bit_valid_o=0`. If `hold_vld`: load, → SEND.
  - LATCH: `bit_valid_o=0`, counter increments each cycle; when counter == `reg_rst_time_i` → IDLE, pulse `frame_done_o`.
- A hold load and a new upstream accept never happen the same cycle (ready low while full); a load frees the hold so ready rises the following cycle.
- `bit_ready_i` outside SEND is ignored.
- `reg_rst_time_i` sampled every cycle in LATCH; change mid-latch takes effect immediately (counter compared with `==`; if new value below counter, latch runs until 16-bit wrap — firmware must not lower it mid-frame).

## Timing
- Reset values: `data_ready_o=1` (first cycle after release), `bit_data_o=0`, `bit_valid_o=0`, `busy_o=0`, `underrun_o=0`, `frame_done_o=0`; state IDLE, all registers zero.
- Accept at cycle 0 in IDLE → hold valid cycle 1 → `bit_valid_o=1` with first bit cycle 2.
- Next bit presented on `bit_data_o` the cycle after `bit_ready_i`; `bit_valid_o` stays high across bit and pixel boundaries when hold full.
- Last bit's `bit_ready_i` at cycle t → `bit_valid_o=0` at t+1; `frame_done_o` at t+1+`reg_rst_time_i`+... precisely: LATCH occupies cycles t+1 … t+1+`reg_rst_time_i`, `frame_done_o` high in the last of them, IDLE at t+2+`reg_rst_time_i`.
- Asynchronous reset mid-frame: everything clears immediately; buffered pixels discarded, no `frame_done_o`.

## Configuration
- `WS28XX_CTL_RGBW_EN` defined: N=32, bits `data_i[31:0]` sent MSB-first.
- Not defined: N=24, `data_i[23:0]` sent MSB-first, `data_i[31:24]` ignored.

## Test plan
- Single pixel 0x00A5F0 last, `reg_rst_time_i`=10, generator model acks each bit after 5 cycles -> bit sequence 0000_0000_1010_0101_1111_0000, `bit_valid_o` low 11 cycles, one `frame_done_o`.
- Three pixels streamed with valid held high, last on third -> 72 bits contiguous, `bit_valid_o` never drops between pixels, `underrun_o` never pulses.
- Second pixel withheld until 20 cycles after first pixel finishes -> `underrun_o` one pulse, `bit_valid_o` low in STALL, resumes 1 cycle after hold fills, frame bits correct.
- New pixel offered during LATCH -> `data_ready_o` low in LATCH, accepted after IDLE entry, next frame starts correctly.
- `rst_n_i` asserted mid-bit of pixel 2 -> all outputs at reset values same cycle, `data_ready_o=1` after release, next frame clean.
- With `WS28XX_CTL_RGBW_EN`: pixel 0x8000_0001 last -> 32 bits, first and last 1, rest 0.
